// File: rtl/camera_frame_reader.sv
`timescale 1ns/1ps
// camera_frame_reader: Avalon-MM master that reads the frame geometry from the
// camera controller, kicks off a capture, polls for completion and then
// streams the frame words out through a 2-entry Avalon-ST buffer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for ctl_start
// RD_W    | read WIDTH (strobe, capture)
// RD_H    | read HEIGHT (strobe, capture), then compute frame word count
// WR_GO   | write 1 to START/done register
// POLL    | read START/done every 2 cycles until done bit or timeout
// WR_CLR  | write 0 to START/done register, clear word counters
// DRAIN   | read CAPTURE_DATA into the buffer, stream it out
// DONE    | one-cycle ctl_done pulse
// ABORT   | poll timeout: write 0 to START/done, one-cycle ctl_error pulse
module camera_frame_reader #(
    parameter int unsigned PIX_PER_WORD_LOG2 = 0,
    parameter logic [23:0] POLL_TIMEOUT      = 24'd5000000
) (
    input  logic        csi_clk,
    input  logic        csi_reset_n,
    input  logic        ctl_start,
    output logic        ctl_busy,
    output logic        ctl_done,
    output logic        ctl_error,
    output logic [31:0] ctl_frame_words,
    output logic [4:0]  avm_m1_address,
    output logic        avm_m1_read,
    input  logic [31:0] avm_m1_readdata,
    output logic        avm_m1_write,
    output logic [31:0] avm_m1_writedata,
    output logic [31:0] aso_data,
    output logic        aso_valid,
    input  logic        aso_ready,
    output logic        aso_sop,
    output logic        aso_eop
);

    localparam logic [4:0] ADDR_START  = 5'h00;
    localparam logic [4:0] ADDR_DATA   = 5'h04;
    localparam logic [4:0] ADDR_WIDTH  = 5'h08;
    localparam logic [4:0] ADDR_HEIGHT = 5'h0a;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_W,
        S_RD_H,
        S_WR_GO,
        S_POLL,
        S_WR_CLR,
        S_DRAIN,
        S_DONE,
        S_ABORT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  phase;
    logic [15:0] width;
    logic [15:0] height;
    logic [31:0] frame_words;
    logic [31:0] issued;
    logic [31:0] delivered;
    logic [23:0] tmo_cnt;
    logic        rd_pend;

    logic [31:0] fifo_mem [0:1];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  fifo_cnt;

    logic [31:0] product;
    logic [31:0] words_calc;
    logic        issue_rd;
    logic        push;
    logic        pop;

    assign product    = 32'(width) * 32'(height);
    assign words_calc = product >> PIX_PER_WORD_LOG2;

    // A data read is only issued when the buffer has room for its return word,
    // counting a read still in flight, so the slave is never over-read.
    assign issue_rd = (state == S_DRAIN) &&
                      ((fifo_cnt + {1'b0, rd_pend}) < 2'd2) &&
                      (issued < frame_words);
    assign push     = rd_pend;
    assign pop      = aso_valid && aso_ready;

    assign ctl_busy        = (state != S_IDLE);
    assign ctl_done        = (state == S_DONE);
    assign ctl_error       = (state == S_ABORT);
    assign ctl_frame_words = frame_words;

    assign aso_valid = (fifo_cnt != 2'd0);
    assign aso_data  = fifo_mem[rd_ptr];
    assign aso_sop   = aso_valid && (delivered == 32'd0);
    assign aso_eop   = aso_valid && (delivered == frame_words - 32'd1);

    // State register and per-state phase counter (restarts on every transition).
    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            state <= S_IDLE;
            phase <= 2'd0;
        end else begin
            state <= state_nxt;
            phase <= (state_nxt != state) ? 2'd0 : phase + 2'd1;
        end
    end

    // Next-state decode and bus strobes; reads and writes live in disjoint states.
    always_comb begin
        state_nxt        = state;
        avm_m1_address   = 5'h00;
        avm_m1_read      = 1'b0;
        avm_m1_write     = 1'b0;
        avm_m1_writedata = 32'd0;
        case (state)
            S_IDLE: begin
                if (ctl_start) state_nxt = S_RD_W;
            end
            S_RD_W: begin
                if (phase == 2'd0) begin
                    avm_m1_read    = 1'b1;
                    avm_m1_address = ADDR_WIDTH;
                end else begin
                    state_nxt = S_RD_H;
                end
            end
            S_RD_H: begin
                if (phase == 2'd0) begin
                    avm_m1_read    = 1'b1;
                    avm_m1_address = ADDR_HEIGHT;
                end else if (phase == 2'd2) begin
                    state_nxt = (words_calc == 32'd0) ? S_DONE : S_WR_GO;
                end
            end
            S_WR_GO: begin
                avm_m1_write     = 1'b1;
                avm_m1_address   = ADDR_START;
                avm_m1_writedata = 32'd1;
                state_nxt        = S_POLL;
            end
            S_POLL: begin
                if (!phase[0] && (tmo_cnt != POLL_TIMEOUT)) begin
                    avm_m1_read    = 1'b1;
                    avm_m1_address = ADDR_START;
                end
                if (phase[0] && avm_m1_readdata[0]) begin
                    state_nxt = S_WR_CLR;
                end else if (tmo_cnt == POLL_TIMEOUT) begin
                    state_nxt = S_ABORT;
                end
            end
            S_WR_CLR: begin
                avm_m1_write     = 1'b1;
                avm_m1_address   = ADDR_START;
                avm_m1_writedata = 32'd0;
                state_nxt        = S_DRAIN;
            end
            S_DRAIN: begin
                if (issue_rd) begin
                    avm_m1_read    = 1'b1;
                    avm_m1_address = ADDR_DATA;
                end
                if ((delivered == frame_words) && (fifo_cnt == 2'd0)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            S_ABORT: begin
                avm_m1_write     = 1'b1;
                avm_m1_address   = ADDR_START;
                avm_m1_writedata = 32'd0;
                state_nxt        = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Geometry capture, word count, poll timeout and drain counters.
    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            width       <= 16'd0;
            height      <= 16'd0;
            frame_words <= 32'd0;
            issued      <= 32'd0;
            delivered   <= 32'd0;
            tmo_cnt     <= 24'd0;
            rd_pend     <= 1'b0;
        end else begin
            if ((state == S_RD_W) && (phase == 2'd1)) width <= avm_m1_readdata[15:0];
            if ((state == S_RD_H) && (phase == 2'd1)) height <= avm_m1_readdata[15:0];
            if ((state == S_RD_H) && (phase == 2'd2)) frame_words <= words_calc;

            if (state == S_WR_GO) begin
                tmo_cnt <= 24'd0;
            end else if (state == S_POLL) begin
                tmo_cnt <= tmo_cnt + 24'd1;
            end

            if (state == S_WR_CLR) begin
                issued    <= 32'd0;
                delivered <= 32'd0;
            end else begin
                if (issue_rd) issued <= issued + 32'd1;
                if (pop) delivered <= delivered + 32'd1;
            end

            rd_pend <= issue_rd;
        end
    end

    // Two-entry stream buffer; push and pop may happen in the same cycle.
    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            fifo_mem[0] <= 32'd0;
            fifo_mem[1] <= 32'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= avm_m1_readdata;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_camera_frame_reader.sv
`timescale 1ns/1ps
// Directed bench for camera_frame_reader: a camera controller slave model plus
// stream monitor per DUT instance (instance 0: 1 pixel/word, instance 1: 2 pixels/word).
module tb_camera_frame_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [1:0]        start;
    logic [1:0]        busy, done, error, rd, wr, valid, sop, eop;
    logic [1:0][31:0]  fw, wdata, adata;
    logic [1:0][4:0]   addr;
    logic              ready, ready_fixed, rand_ready, clr;
    logic [15:0]       s_w [2];
    logic [15:0]       s_h [2];
    logic [1:0]        s_never;

    int errors = 0;
    int checks = 0;

    // Stream ready: fixed level, or low roughly one cycle in three.
    always @(negedge clk) ready = rand_ready ? ($urandom_range(0, 2) != 0) : ready_fixed;

    for (genvar g = 0; g < 2; g++) begin : gi
        logic [31:0] rdata;
        logic        done_flag, armed, stall;
        logic [3:0]  cd;
        logic [31:0] ptr, stall_data;
        logic [31:0] st_data [0:15];
        logic [15:0] sop_mask, eop_mask;
        logic [31:0] wr_val [0:3];
        int          st_n, wr_n, rd4_n, done_n, err_n, clash, hold_viol;

        camera_frame_reader #(.PIX_PER_WORD_LOG2(g), .POLL_TIMEOUT(24'd100)) u_dut (
            .csi_clk(clk), .csi_reset_n(rst_n),
            .ctl_start(start[g]), .ctl_busy(busy[g]), .ctl_done(done[g]), .ctl_error(error[g]),
            .ctl_frame_words(fw[g]),
            .avm_m1_address(addr[g]), .avm_m1_read(rd[g]), .avm_m1_readdata(rdata),
            .avm_m1_write(wr[g]), .avm_m1_writedata(wdata[g]),
            .aso_data(adata[g]), .aso_valid(valid[g]), .aso_ready(ready),
            .aso_sop(sop[g]), .aso_eop(eop[g])
        );

        // Slave register model (latency 1, done 10 cycles after start) and stream/bus logging.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata <= 32'd0; done_flag <= 1'b0; armed <= 1'b0; cd <= 4'd0; ptr <= 32'h100;
                stall <= 1'b0; stall_data <= 32'd0; sop_mask <= 16'd0; eop_mask <= 16'd0;
                st_n <= 0; wr_n <= 0; rd4_n <= 0; done_n <= 0; err_n <= 0; clash <= 0; hold_viol <= 0;
                for (int i = 0; i < 4; i++) wr_val[i] <= 32'd0;
            end else begin
                if (clr) begin
                    sop_mask <= 16'd0; eop_mask <= 16'd0;
                    st_n <= 0; wr_n <= 0; rd4_n <= 0; done_n <= 0; err_n <= 0; clash <= 0; hold_viol <= 0;
                end else begin
                    if (rd[g] && wr[g]) clash <= clash + 1;
                    if (valid[g] && ready) begin
                        if (st_n < 16) begin
                            st_data[st_n[3:0]]  <= adata[g];
                            sop_mask[st_n[3:0]] <= sop[g];
                            eop_mask[st_n[3:0]] <= eop[g];
                        end
                        st_n <= st_n + 1;
                    end
                    if (stall && (!valid[g] || adata[g] != stall_data)) hold_viol <= hold_viol + 1;
                    if (done[g]) done_n <= done_n + 1;
                    if (error[g]) err_n <= err_n + 1;
                    if (rd[g] && addr[g] == 5'h04) rd4_n <= rd4_n + 1;
                    if (wr[g] && addr[g] == 5'h00) begin
                        if (wr_n < 4) wr_val[wr_n[1:0]] <= wdata[g];
                        wr_n <= wr_n + 1;
                    end
                end
                stall      <= valid[g] && !ready;
                stall_data <= adata[g];
                if (rd[g]) begin
                    case (addr[g])
                        5'h00: rdata <= {31'd0, done_flag};
                        5'h04: begin rdata <= ptr; ptr <= ptr + 32'd1; end
                        5'h08: rdata <= {16'd0, s_w[g]};
                        5'h0a: rdata <= {16'd0, s_h[g]};
                        default: rdata <= 32'hdead_beef;
                    endcase
                end
                if (wr[g] && addr[g] == 5'h00) begin
                    armed     <= wdata[g][0];
                    cd        <= 4'd10;
                    done_flag <= 1'b0;
                    if (wdata[g][0]) ptr <= 32'h100;
                end else begin
                    if (armed && cd != 4'd0) cd <= cd - 4'd1;
                    done_flag <= armed && (cd == 4'd0) && !s_never[g];
                end
            end
        end
    end

    task automatic pulse_start(input int g);
        @(negedge clk) start[g] = 1'b1;
        @(negedge clk) start[g] = 1'b0;
    endtask

    task automatic clear_logs();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    task automatic wait_idle(input int g, input int maxc, output int cyc);
        cyc = 0;
        while (busy[g] && cyc < maxc) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 2'b00; clr = 1'b0; ready_fixed = 1'b1; rand_ready = 1'b0;
        s_w[0] = 16'd4; s_h[0] = 16'd2; s_w[1] = 16'd3; s_h[1] = 16'd2; s_never = 2'b00;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b want 00", busy); end
        checks++; if ((rd | wr) !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", rd | wr); end
        checks++; if (addr[0] !== 5'h00) begin errors++; $display("FAIL reset_addr: got %0h want 0", addr[0]); end
        checks++; if ((valid | sop | eop | done | error) !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", valid | sop | eop | done | error); end
        checks++; if (fw[0] !== 32'd0 || adata[0] !== 32'd0) begin errors++; $display("FAIL reset_data: got fw=%0h data=%0h want 0", fw[0], adata[0]); end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_idle: got %b want 0", busy[0]); end
    endtask

    task automatic test_basic_frame();
        int cyc;
        s_w[0] = 16'd4; s_h[0] = 16'd2;
        clear_logs();
        pulse_start(0);
        wait_idle(0, 400, cyc);
        checks++; if (cyc >= 400) begin errors++; $display("FAIL basic_timeout: got %0d cycles want <400", cyc); end
        checks++; if (gi[0].st_n !== 8) begin errors++; $display("FAIL basic_count: got %0d want 8", gi[0].st_n); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (gi[0].st_data[i] !== 32'h100 + i) begin errors++; $display("FAIL basic_data[%0d]: got %0h want %0h", i, gi[0].st_data[i], 32'h100 + i); end
        end
        checks++; if (gi[0].sop_mask !== 16'h0001) begin errors++; $display("FAIL basic_sop: got %0h want 1", gi[0].sop_mask); end
        checks++; if (gi[0].eop_mask !== 16'h0080) begin errors++; $display("FAIL basic_eop: got %0h want 80", gi[0].eop_mask); end
        checks++; if (gi[0].done_n !== 1 || gi[0].err_n !== 0) begin errors++; $display("FAIL basic_done: got done=%0d err=%0d want 1/0", gi[0].done_n, gi[0].err_n); end
        checks++; if (gi[0].wr_n !== 2 || gi[0].wr_val[0] !== 32'd1 || gi[0].wr_val[1] !== 32'd0) begin errors++; $display("FAIL basic_writes: got n=%0d %0h,%0h want 2 1,0", gi[0].wr_n, gi[0].wr_val[0], gi[0].wr_val[1]); end
        checks++; if (gi[0].rd4_n !== 8) begin errors++; $display("FAIL basic_reads: got %0d want 8", gi[0].rd4_n); end
        checks++; if (gi[0].clash !== 0) begin errors++; $display("FAIL basic_clash: got %0d want 0", gi[0].clash); end
        checks++; if (fw[0] !== 32'd8) begin errors++; $display("FAIL basic_words: got %0d want 8", fw[0]); end
    endtask

    task automatic test_back_pressure();
        int cyc;
        s_w[0] = 16'd4; s_h[0] = 16'd2;
        clear_logs();
        rand_ready = 1'b1;
        pulse_start(0);
        wait_idle(0, 600, cyc);
        rand_ready = 1'b0;
        checks++; if (gi[0].st_n !== 8) begin errors++; $display("FAIL bp_count: got %0d want 8", gi[0].st_n); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (gi[0].st_data[i] !== 32'h100 + i) begin errors++; $display("FAIL bp_data[%0d]: got %0h want %0h", i, gi[0].st_data[i], 32'h100 + i); end
        end
        checks++; if (gi[0].rd4_n !== 8) begin errors++; $display("FAIL bp_reads: got %0d want 8", gi[0].rd4_n); end
        checks++; if (gi[0].hold_viol !== 0) begin errors++; $display("FAIL bp_hold: got %0d want 0", gi[0].hold_viol); end
        checks++; if (gi[0].sop_mask !== 16'h0001 || gi[0].eop_mask !== 16'h0080) begin errors++; $display("FAIL bp_framing: got sop=%0h eop=%0h want 1/80", gi[0].sop_mask, gi[0].eop_mask); end
        checks++; if (gi[0].done_n !== 1) begin errors++; $display("FAIL bp_done: got %0d want 1", gi[0].done_n); end
    endtask

    task automatic test_empty_frame();
        int cyc;
        s_w[0] = 16'd0; s_h[0] = 16'd240;
        clear_logs();
        pulse_start(0);
        wait_idle(0, 100, cyc);
        checks++; if (gi[0].wr_n !== 0) begin errors++; $display("FAIL empty_writes: got %0d want 0", gi[0].wr_n); end
        checks++; if (gi[0].st_n !== 0 || gi[0].rd4_n !== 0) begin errors++; $display("FAIL empty_stream: got words=%0d reads=%0d want 0/0", gi[0].st_n, gi[0].rd4_n); end
        checks++; if (gi[0].done_n !== 1) begin errors++; $display("FAIL empty_done: got %0d want 1", gi[0].done_n); end
        checks++; if (fw[0] !== 32'd0) begin errors++; $display("FAIL empty_words: got %0d want 0", fw[0]); end
    endtask

    task automatic test_timeout();
        int cyc;
        s_w[0] = 16'd4; s_h[0] = 16'd2; s_never[0] = 1'b1;
        clear_logs();
        pulse_start(0);
        wait_idle(0, 400, cyc);
        s_never[0] = 1'b0;
        checks++; if (cyc < 104 || cyc > 112) begin errors++; $display("FAIL tmo_cycles: got %0d want 104..112", cyc); end
        checks++; if (gi[0].err_n !== 1 || gi[0].done_n !== 0) begin errors++; $display("FAIL tmo_pulses: got err=%0d done=%0d want 1/0", gi[0].err_n, gi[0].done_n); end
        checks++; if (gi[0].wr_n !== 2 || gi[0].wr_val[0] !== 32'd1 || gi[0].wr_val[1] !== 32'd0) begin errors++; $display("FAIL tmo_writes: got n=%0d %0h,%0h want 2 1,0", gi[0].wr_n, gi[0].wr_val[0], gi[0].wr_val[1]); end
        checks++; if (gi[0].st_n !== 0 || busy[0] !== 1'b0) begin errors++; $display("FAIL tmo_idle: got words=%0d busy=%b want 0/0", gi[0].st_n, busy[0]); end
    endtask

    task automatic test_packing();
        int cyc;
        s_w[1] = 16'd3; s_h[1] = 16'd2;
        clear_logs();
        pulse_start(1);
        wait_idle(1, 400, cyc);
        checks++; if (fw[1] !== 32'd3 || gi[1].st_n !== 3 || gi[1].rd4_n !== 3) begin errors++; $display("FAIL pack_count: got fw=%0d words=%0d reads=%0d want 3", fw[1], gi[1].st_n, gi[1].rd4_n); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (gi[1].st_data[i] !== 32'h100 + i) begin errors++; $display("FAIL pack_data[%0d]: got %0h want %0h", i, gi[1].st_data[i], 32'h100 + i); end
        end
        checks++; if (gi[1].sop_mask !== 16'h0001 || gi[1].eop_mask !== 16'h0004) begin errors++; $display("FAIL pack_framing: got sop=%0h eop=%0h want 1/4", gi[1].sop_mask, gi[1].eop_mask); end
        s_w[0] = 16'd1; s_h[0] = 16'd1;
        clear_logs();
        pulse_start(0);
        wait_idle(0, 400, cyc);
        checks++; if (fw[0] !== 32'd1 || gi[0].st_n !== 1 || gi[0].st_data[0] !== 32'h100) begin errors++; $display("FAIL single_word: got fw=%0d words=%0d data=%0h want 1/1/100", fw[0], gi[0].st_n, gi[0].st_data[0]); end
        checks++; if (gi[0].sop_mask !== 16'h0001 || gi[0].eop_mask !== 16'h0001) begin errors++; $display("FAIL single_framing: got sop=%0h eop=%0h want 1/1", gi[0].sop_mask, gi[0].eop_mask); end
    endtask

    task automatic test_reset_mid_drain();
        int cyc;
        s_w[0] = 16'd4; s_h[0] = 16'd2;
        ready_fixed = 1'b0;
        clear_logs();
        pulse_start(0);
        cyc = 0;
        while (!valid[0] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (valid[0] !== 1'b1) begin errors++; $display("FAIL mid_reach_drain: got valid=%b want 1", valid[0]); end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ((busy[0] | valid[0] | rd[0] | wr[0] | sop[0] | eop[0]) !== 1'b0) begin errors++; $display("FAIL mid_async_flags: got busy=%b valid=%b rd=%b wr=%b", busy[0], valid[0], rd[0], wr[0]); end
        checks++; if (fw[0] !== 32'd0 || adata[0] !== 32'd0 || addr[0] !== 5'h00) begin errors++; $display("FAIL mid_async_data: got fw=%0h data=%0h addr=%0h want 0", fw[0], adata[0], addr[0]); end
        @(negedge clk) rst_n = 1'b1;
        ready_fixed = 1'b1;
        repeat (2) @(negedge clk);
        pulse_start(0);
        repeat (5) @(negedge clk);
        pulse_start(0);
        wait_idle(0, 400, cyc);
        checks++; if (gi[0].st_n !== 8) begin errors++; $display("FAIL mid_rerun_count: got %0d want 8", gi[0].st_n); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (gi[0].st_data[i] !== 32'h100 + i) begin errors++; $display("FAIL mid_rerun_data[%0d]: got %0h want %0h", i, gi[0].st_data[i], 32'h100 + i); end
        end
        checks++; if (gi[0].done_n !== 1 || gi[0].wr_n !== 2 || gi[0].rd4_n !== 8) begin errors++; $display("FAIL mid_busy_start: got done=%0d writes=%0d reads=%0d want 1/2/8", gi[0].done_n, gi[0].wr_n, gi[0].rd4_n); end
        repeat (5) @(negedge clk);
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL mid_no_retrigger: got busy=%b want 0", busy[0]); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_back_pressure();
        test_empty_frame();
        test_timeout();
        test_packing();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
